// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared types and header helpers for the matrix-vector engine
//
// Purpose: FSM state encoding plus the element-size legality check and the
//          packing arithmetic used when walking packed vectors and weight rows.
// Ports:   none (package)
package mvm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD_IN,
    ROW,
    WRITE,
    DONE
  } state_t;

  // Only power-of-two sizes that tile a word exactly are legal.
  function automatic logic size_legal(input int s, input int data_w);
    return ((s == 1) || (s == 2) || (s == 4) || (s == 8) || (s == 16)) && (s <= data_w);
  endfunction

  function automatic int elems_per_word(input int s, input int data_w);
    return (s == 0) ? 1 : (data_w / s);
  endfunction

  function automatic int words_per_row(input int n, input int s, input int data_w);
    return (n * s + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/mvm_unpack.sv
// rtl/mvm_unpack.sv - extract one packed element from a memory word
//
// Purpose: combinational selector; element `index` of `word` holding elements of
//          `size` bits packed MSB-first, returned zero-extended to DATA_W.
// Ports:   word  in  DATA_W  packed memory word
//          size  in  DATA_W  element size in bits (legal sizes only)
//          index in  DATA_W  element position within the word, 0 = MSBs
//          elem  out DATA_W  zero-extended element
module mvm_unpack
  import mvm_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] size,
  input  logic [DATA_W-1:0] index,
  output logic [DATA_W-1:0] elem
);

  logic [DATA_W:0]   mask;
  logic [31:0]       shamt;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    // One extra bit so a full-width element (size == DATA_W) still gets an all-ones mask.
    mask    = ((DATA_W+1)'(1) << size) - (DATA_W+1)'(1);
    shamt   = 32'(DATA_W) - 32'(size) * (32'(index) + 32'd1);
    shifted = word >> shamt;
    elem    = shifted & mask[DATA_W-1:0];
  end

endmodule

// File: rtl/mvm_engine.sv
// rtl/mvm_engine.sv - packed matrix-vector multiply engine, y = W*x
//
// Purpose: reads header + packed vector from the input SRAM and header + packed
//          weight rows from the weight memory, accumulates one element per cycle
//          and writes y[r] to the input SRAM at OUT_BASE+r.
// Option:  MVM_SATURATE_EN - saturating accumulator and written result
//          (default: wrapping accumulator, truncated result).
// Ports:   clk, reset (async, active-high)
//          dut_run / dut_busy / dut_error        run handshake and sticky header error
//          dut_sram_read_address, sram_dut_read_data    input SRAM read port (1-cycle latency)
//          dut_wmem_read_address, wmem_dut_read_data    weight memory read port (1-cycle latency)
//          dut_sram_write_address/_data/_enable         result write port
module mvm_engine
  import mvm_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter int                ACC_W    = 32,
  parameter int                MAX_N    = 16,
  parameter logic [ADDR_W-1:0] OUT_BASE = 'h080
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic              dut_error,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable
);

  localparam int CW = $clog2(MAX_N + 1);
  localparam int XW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int EW = $clog2(DATA_W) + 1;

  state_t            state;
  logic [1:0]        hphase;
  logic [DATA_W-1:0] n_hdr;
  logic [DATA_W-1:0] n_w;
  logic [CW-1:0]     n_q;
  logic [DATA_W-1:0] s_q;
  logic [EW-1:0]     epw_q;
  logic [EW-1:0]     eidx;
  logic [CW-1:0]     c;
  logic [CW-1:0]     r;
  logic              rd_wait;
  logic [DATA_W-1:0] word_buf;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] x_buf [MAX_N];

  logic [DATA_W-1:0]   src_word;
  logic [DATA_W-1:0]   eidx_ext;
  logic [DATA_W-1:0]   elem;
  logic [XW-1:0]       x_idx;
  logic [DATA_W-1:0]   cur_x;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    acc_next;
  logic [DATA_W-1:0]   result;
  logic                hdr_bad;
  logic                last_elem;
  logic                last_in_word;

  // The first element of a word comes straight off the read port; the word is
  // captured so later elements of it come from word_buf while the port idles.
  always_comb begin
    src_word = word_buf;
    if (eidx == '0) begin
      src_word = (state == LOAD_IN) ? sram_dut_read_data : wmem_dut_read_data;
    end
    eidx_ext     = DATA_W'(eidx);
    x_idx        = XW'(c);
    cur_x        = x_buf[x_idx];
    prod         = {{DATA_W{1'b0}}, elem} * {{DATA_W{1'b0}}, cur_x};
    sum          = {1'b0, acc} + (ACC_W+1)'(prod);
    last_elem    = (c == n_q - CW'(1));
    last_in_word = (eidx == epw_q - EW'(1));
    hdr_bad      = (n_hdr == '0) || (n_hdr > DATA_W'(MAX_N)) ||
                   !size_legal(int'(sram_dut_read_data), DATA_W) ||
                   (n_w != n_hdr) || (wmem_dut_read_data != sram_dut_read_data);
  end

`ifdef MVM_SATURATE_EN
  always_comb begin
    acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    result   = (|acc_next[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : acc_next[DATA_W-1:0];
  end
`else
  always_comb begin
    acc_next = sum[ACC_W-1:0];
    result   = acc_next[DATA_W-1:0];
  end
`endif

  mvm_unpack #(.DATA_W(DATA_W)) u_unpack (
    .word  (src_word),
    .size  (s_q),
    .index (eidx_ext),
    .elem  (elem)
  );

  always_ff @(posedge clk) begin
    if (state == LOAD_IN && !rd_wait) begin
      x_buf[x_idx] <= elem;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      hphase                 <= '0;
      n_hdr                  <= '0;
      n_w                    <= '0;
      n_q                    <= '0;
      s_q                    <= '0;
      epw_q                  <= '0;
      eidx                   <= '0;
      c                      <= '0;
      r                      <= '0;
      rd_wait                <= 1'b0;
      word_buf               <= '0;
      acc                    <= '0;
      dut_busy               <= 1'b0;
      dut_error              <= 1'b0;
      dut_sram_read_address  <= '0;
      dut_wmem_read_address  <= '0;
      dut_sram_write_address <= '0;
      dut_sram_write_data    <= '0;
      dut_sram_write_enable  <= 1'b0;
    end else begin
      dut_sram_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (dut_run) begin
            state                 <= HDR;
            hphase                <= '0;
            dut_busy              <= 1'b1;
            dut_error             <= 1'b0;
            dut_sram_read_address <= '0;
            dut_wmem_read_address <= '0;
          end
        end

        HDR: begin
          case (hphase)
            2'd0: begin
              dut_sram_read_address <= ADDR_W'(1);
              dut_wmem_read_address <= ADDR_W'(1);
              hphase                <= 2'd1;
            end
            2'd1: begin
              n_hdr                 <= sram_dut_read_data;
              n_w                   <= wmem_dut_read_data;
              dut_sram_read_address <= ADDR_W'(2);
              dut_wmem_read_address <= ADDR_W'(2);
              hphase                <= 2'd2;
            end
            default: begin
              if (hdr_bad) begin
                dut_error <= 1'b1;
                dut_busy  <= 1'b0;
                state     <= DONE;
              end else begin
                n_q     <= CW'(n_hdr);
                s_q     <= sram_dut_read_data;
                epw_q   <= EW'(elems_per_word(int'(sram_dut_read_data), DATA_W));
                c       <= '0;
                eidx    <= '0;
                r       <= '0;
                acc     <= '0;
                // Word 2 was already presented during this cycle, so data is ready next cycle.
                rd_wait <= 1'b0;
                state   <= LOAD_IN;
              end
            end
          endcase
        end

        LOAD_IN, ROW: begin
          if (rd_wait) begin
            rd_wait <= 1'b0;
          end else begin
            if (eidx == '0) begin
              word_buf <= src_word;
            end
            if (last_elem) begin
              c    <= '0;
              eidx <= '0;
              if (state == LOAD_IN) begin
                rd_wait <= 1'b1;
                state   <= ROW;
              end else begin
                acc                    <= '0;
                dut_sram_write_enable  <= 1'b1;
                dut_sram_write_address <= OUT_BASE + ADDR_W'(r);
                dut_sram_write_data    <= result;
                // Next row starts on a fresh word; leftover packed elements are skipped.
                dut_wmem_read_address  <= dut_wmem_read_address + ADDR_W'(1);
                state                  <= WRITE;
              end
            end else begin
              c <= c + CW'(1);
              if (state == ROW) begin
                acc <= acc_next;
              end
              if (last_in_word) begin
                eidx    <= '0;
                rd_wait <= 1'b1;
                if (state == LOAD_IN) begin
                  dut_sram_read_address <= dut_sram_read_address + ADDR_W'(1);
                end else begin
                  dut_wmem_read_address <= dut_wmem_read_address + ADDR_W'(1);
                end
              end else begin
                eidx <= eidx + EW'(1);
              end
            end
          end
        end

        WRITE: begin
          r <= r + CW'(1);
          if (r == n_q - CW'(1)) begin
            dut_busy <= 1'b0;
            state    <= DONE;
          end else begin
            rd_wait <= 1'b1;
            state   <= ROW;
          end
        end

        DONE: begin
          if (!dut_run) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_engine.sv
// tb/tb_mvm_engine.sv - scoreboard bench for mvm_engine
module tb_mvm_engine;

  localparam logic [11:0] OUT_BASE = 12'h080;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dut_run = 1'b0;
  logic        dut_busy;
  logic        dut_error;
  logic [11:0] dut_sram_read_address;
  logic [15:0] sram_dut_read_data = '0;
  logic [11:0] dut_wmem_read_address;
  logic [15:0] wmem_dut_read_data = '0;
  logic [11:0] dut_sram_write_address;
  logic [15:0] dut_sram_write_data;
  logic        dut_sram_write_enable;

  mvm_engine #(.ADDR_W(12), .DATA_W(16), .ACC_W(32), .MAX_N(16), .OUT_BASE(OUT_BASE)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_error              (dut_error),
    .dut_sram_read_address  (dut_sram_read_address),
    .sram_dut_read_data     (sram_dut_read_data),
    .dut_wmem_read_address  (dut_wmem_read_address),
    .wmem_dut_read_data     (wmem_dut_read_data),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data),
    .dut_sram_write_enable  (dut_sram_write_enable)
  );

  always #5 clk = ~clk;

  logic [15:0] sram [0:4095];
  logic [15:0] wmem [0:4095];

  always @(posedge clk) begin
    sram_dut_read_data <= sram[dut_sram_read_address];
    wmem_dut_read_data <= wmem[dut_wmem_read_address];
    if (dut_sram_write_enable) sram[dut_sram_write_address] <= dut_sram_write_data;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  logic [11:0] exp_addr_q [$];
  logic [15:0] exp_data_q [$];
  logic [11:0] ea;
  logic [15:0] ed;
  int cyc_cnt = 0, last_wr_cyc = 0, fall_cyc = 0, wr_count = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc_cnt++;
    if (!reset && dut_sram_write_enable) begin
      wr_count++;
      last_wr_cyc = cyc_cnt;
      if (exp_addr_q.size() == 0) begin
        check("unexpected_write", 32'(dut_sram_write_address), 32'hFFFF_FFFF);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check("wr_addr", 32'(dut_sram_write_address), 32'(ea));
        check("wr_data", 32'(dut_sram_write_data), 32'(ed));
      end
    end
    if (prev_busy && !dut_busy) fall_cyc = cyc_cnt;
    prev_busy = dut_busy;
  end

  int xv [16];
  int wm [16][16];

  task automatic load(input int n, input int s, input int nw, input int sw, input bit good);
    int epw, wpr, sh;
    longint acc;
    logic [15:0] y;
    for (int a = 0; a < 4096; a++) begin
      sram[a] = '0;
      wmem[a] = '0;
    end
    sram[0] = 16'(n);
    sram[1] = 16'(s);
    wmem[0] = 16'(nw);
    wmem[1] = 16'(sw);
    if (good) begin
      epw = 16 / s;
      wpr = (n + epw - 1) / epw;
      for (int i = 0; i < n; i++) begin
        sh = 16 - s * (i % epw + 1);
        sram[2 + i / epw] = sram[2 + i / epw] | 16'(xv[i] << sh);
      end
      for (int row = 0; row < n; row++) begin
        for (int col = 0; col < n; col++) begin
          sh = 16 - s * (col % epw + 1);
          wmem[2 + row * wpr + col / epw] = wmem[2 + row * wpr + col / epw] | 16'(wm[row][col] << sh);
        end
      end
      for (int row = 0; row < n; row++) begin
        acc = 0;
        for (int col = 0; col < n; col++) begin
          acc = acc + longint'(xv[col]) * longint'(wm[row][col]);
`ifdef MVM_SATURATE_EN
          if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
`else
          acc = acc & 64'hFFFF_FFFF;
`endif
        end
`ifdef MVM_SATURATE_EN
        y = (acc > 64'hFFFF) ? 16'hFFFF : 16'(acc);
`else
        y = 16'(acc);
`endif
        exp_addr_q.push_back(OUT_BASE + 12'(row));
        exp_data_q.push_back(y);
      end
    end
  endtask

  task automatic do_run(input bit hold, input bit exp_err, input bit good, input string tag);
    int cyc;
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    if (!hold) dut_run = 1'b0;
    check({tag, "_busy_rise"}, 32'(dut_busy), 1);
    check({tag, "_err_clear"}, 32'(dut_error), 0);
    cyc = 0;
    while (dut_busy && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 32'(cyc < 5000), 1);
    if (hold) begin
      repeat (3) @(negedge clk);
      check({tag, "_no_retrigger"}, 32'(dut_busy), 0);
      dut_run = 1'b0;
    end
    repeat (2) @(negedge clk);
    check({tag, "_drain"}, 32'(exp_addr_q.size()), 0);
    check({tag, "_error"}, 32'(dut_error), 32'(exp_err));
    if (good) check({tag, "_busy_fall"}, 32'(fall_cyc - last_wr_cyc), 1);
    else      check({tag, "_err_busy_len"}, 32'(cyc <= 4), 1);
  endtask

  int n_r, s_r, mask_r, base_wr, guard;
  int sizes [5] = '{1, 2, 4, 8, 16};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(dut_busy), 0);
    check("rst_error", 32'(dut_error), 0);
    check("rst_we", 32'(dut_sram_write_enable), 0);
    check("rst_raddr", 32'(dut_sram_read_address), 0);
    check("rst_waddr", 32'(dut_wmem_read_address), 0);
    reset = 1'b0;

    // Identity weights, run held high afterwards
    for (int i = 0; i < 4; i++) begin
      xv[i] = i + 1;
      for (int j = 0; j < 4; j++) wm[i][j] = (i == j) ? 1 : 0;
    end
    load(4, 16, 4, 16, 1'b1);
    do_run(1'b1, 1'b0, 1'b1, "ident");

    for (int i = 0; i < 16; i++) begin
      xv[i] = 2;
      for (int j = 0; j < 16; j++) wm[i][j] = 3;
    end
    load(16, 8, 16, 8, 1'b1);
    do_run(1'b0, 1'b0, 1'b1, "s8");

    for (int i = 0; i < 16; i++) begin
      xv[i] = 3;
      for (int j = 0; j < 16; j++) wm[i][j] = 3;
    end
    load(16, 2, 16, 2, 1'b1);
    do_run(1'b0, 1'b0, 1'b1, "s2");

    for (int i = 0; i < 5; i++) begin
      xv[i] = 1;
      for (int j = 0; j < 5; j++) wm[i][j] = (j <= i) ? 1 : 0;
    end
    load(5, 1, 5, 1, 1'b1);
    do_run(1'b0, 1'b0, 1'b1, "s1");

    load(4, 3, 4, 3, 1'b0);
    do_run(1'b0, 1'b1, 1'b0, "bad_s");
    load(4, 16, 5, 16, 1'b0);
    do_run(1'b0, 1'b1, 1'b0, "bad_nw");
    load(4, 8, 4, 16, 1'b0);
    do_run(1'b0, 1'b1, 1'b0, "bad_sw");
    load(17, 16, 17, 16, 1'b0);
    do_run(1'b0, 1'b1, 1'b0, "bad_n17");

    for (int i = 0; i < 2; i++) begin
      xv[i] = 16'hFFFF;
      for (int j = 0; j < 2; j++) wm[i][j] = 16'hFFFF;
    end
    load(2, 16, 2, 16, 1'b1);
    do_run(1'b0, 1'b0, 1'b1, "ovf");

    // Reset while row 2 is accumulating
    for (int i = 0; i < 4; i++) begin
      xv[i] = i + 1;
      for (int j = 0; j < 4; j++) wm[i][j] = 1;
    end
    load(4, 16, 4, 16, 1'b1);
    base_wr = wr_count;
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    guard = 0;
    while (wr_count < base_wr + 2 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("mid_rst_reach_row2", 32'(guard < 500), 1);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(dut_busy), 0);
    check("mid_rst_we", 32'(dut_sram_write_enable), 0);
    check("mid_rst_wdata", 32'(dut_sram_write_data), 0);
    check("mid_rst_raddr", 32'(dut_sram_read_address), 0);
    check("mid_rst_wmaddr", 32'(dut_wmem_read_address), 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    load(4, 16, 4, 16, 1'b1);
    do_run(1'b0, 1'b0, 1'b1, "after_rst");

    for (int t = 0; t < 4; t++) begin
      n_r = $urandom_range(16, 1);
      s_r = sizes[$urandom_range(4, 0)];
      mask_r = (1 << s_r) - 1;
      for (int i = 0; i < 16; i++) begin
        xv[i] = int'($urandom) & mask_r;
        for (int j = 0; j < 16; j++) wm[i][j] = int'($urandom) & mask_r;
      end
      load(n_r, s_r, n_r, s_r, 1'b1);
      do_run(1'b0, 1'b0, 1'b1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
